// File: rtl/wb_set_assoc_cache.sv
// Write-back, set-associative cache with true-LRU replacement and a line-wide memory port.
// Define CACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module wb_set_assoc_cache #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WAY_BITS   = 2,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned BLOCK_BITS = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_ni,
  input  logic [ADDR_W-1:0]                   address_i,
  input  logic                                c_read_i,
  input  logic                                c_wr_i,
  input  logic [DATA_W-1:0]                   c_write_data_i,
  output logic [DATA_W-1:0]                   c_data_o,
  output logic                                c_busywait_o,
  output logic                                c_m_read_o,
  output logic                                c_m_wr_o,
  output logic [ADDR_W-BLOCK_BITS-3:0]        c_m_address_o,
  output logic [(DATA_W<<BLOCK_BITS)-1:0]     c_m_write_data_o,
  input  logic [(DATA_W<<BLOCK_BITS)-1:0]     c_m_read_data_i,
  input  logic                                c_m_busywait_i,
  input  logic                                m_read_done,
  input  logic                                m_write_done
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                         hit_cnt_o,
  output logic [31:0]                         miss_cnt_o
`endif
);

  localparam int unsigned Ways      = 1 << WAY_BITS;
  localparam int unsigned Sets      = 1 << INDEX_BITS;
  localparam int unsigned LineW     = DATA_W << BLOCK_BITS;
  localparam int unsigned TagW      = ADDR_W - INDEX_BITS - BLOCK_BITS - 2;
  localparam int unsigned LineAddrW = ADDR_W - BLOCK_BITS - 2;
  localparam int unsigned WayW      = (WAY_BITS > 0) ? WAY_BITS : 1;
  localparam int unsigned OffW      = (BLOCK_BITS > 0) ? BLOCK_BITS : 1;

  typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

  state_e                 state_q;
  logic                   m_rd_q, m_wr_q;
  logic [WayW-1:0]        victim_q;
  logic [LineAddrW-1:0]   line_q;

  logic [LineW-1:0]       data_q  [Sets][Ways];
  logic [TagW-1:0]        tag_q   [Sets][Ways];
  logic [Ways-1:0]        valid_q [Sets];
  logic [Ways-1:0]        dirty_q [Sets];
  logic [WayW-1:0]        age_q   [Sets][Ways];

  logic [TagW-1:0]        req_tag;
  logic [INDEX_BITS-1:0]  req_idx, miss_idx;
  logic [OffW-1:0]        req_off;
  logic                   req, hit, victim_found;
  logic [WayW-1:0]        hit_way, victim, old_age;
  logic [WayW-1:0]        age_next [Ways];
  logic [LineW-1:0]       hit_line;
  logic                   hit_en, wr_hit_en, miss_en, wb_done, fill_done, victim_dirty;

  assign req_tag  = TagW'(address_i >> (INDEX_BITS + BLOCK_BITS + 2));
  assign req_idx  = INDEX_BITS'(address_i >> (BLOCK_BITS + 2));
  assign req_off  = (BLOCK_BITS == 0) ? '0 : OffW'(address_i >> 2);
  assign miss_idx = line_q[INDEX_BITS-1:0];
  assign req      = c_read_i | c_wr_i;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < Ways; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  // Prefer the lowest free way; otherwise evict the oldest (age Ways-1).
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    for (int w = 0; w < Ways; w++) begin
      if (!victim_found && !valid_q[req_idx][w]) begin
        victim       = WayW'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < Ways; w++) begin
        if (age_q[req_idx][w] == WayW'(Ways - 1)) victim = WayW'(w);
      end
    end
  end

  always_comb begin
    old_age = age_q[req_idx][hit_way];
    for (int w = 0; w < Ways; w++) begin
      if (WayW'(w) == hit_way)             age_next[w] = '0;
      else if (age_q[req_idx][w] < old_age) age_next[w] = age_q[req_idx][w] + 1'b1;
      else                                  age_next[w] = age_q[req_idx][w];
    end
  end

  assign hit_line     = data_q[req_idx][hit_way];
  assign hit_en       = (state_q == StIdle) && req && hit;
  assign wr_hit_en    = hit_en && c_wr_i;
  assign miss_en      = (state_q == StIdle) && req && !hit;
  assign wb_done      = (state_q == StWriteback) && m_write_done && !c_m_busywait_i;
  assign fill_done    = (state_q == StRefill) && m_read_done && !c_m_busywait_i;
  assign victim_dirty = valid_q[req_idx][victim] && dirty_q[req_idx][victim];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      m_rd_q   <= 1'b0;
      m_wr_q   <= 1'b0;
      victim_q <= '0;
      line_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (miss_en) begin
            victim_q <= victim;
            line_q   <= LineAddrW'(address_i >> (BLOCK_BITS + 2));
            if (victim_dirty) begin
              state_q <= StWriteback;
              m_wr_q  <= 1'b1;
            end else begin
              state_q <= StRefill;
              m_rd_q  <= 1'b1;
            end
          end
        end
        StWriteback: begin
          if (wb_done) begin
            state_q <= StRefill;
            m_wr_q  <= 1'b0;
            m_rd_q  <= 1'b1;
          end
        end
        StRefill: begin
          if (fill_done) begin
            state_q <= StIdle;
            m_rd_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < Sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < Ways; w++) age_q[s][w] <= WayW'(w);
      end
    end else begin
      if (wr_hit_en) dirty_q[req_idx][hit_way] <= 1'b1;
      if (wb_done)   dirty_q[miss_idx][victim_q] <= 1'b0;
      if (fill_done) begin
        valid_q[miss_idx][victim_q] <= 1'b1;
        dirty_q[miss_idx][victim_q] <= 1'b0;
      end
      if (hit_en) begin
        for (int w = 0; w < Ways; w++) age_q[req_idx][w] <= age_next[w];
      end
    end
  end

  // Payload arrays need no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_q[miss_idx][victim_q] <= c_m_read_data_i;
      tag_q[miss_idx][victim_q]  <= line_q[LineAddrW-1 -: TagW];
    end
    if (wr_hit_en) data_q[req_idx][hit_way][req_off*DATA_W +: DATA_W] <= c_write_data_i;
  end

  assign c_data_o     = (reset_ni && hit) ? hit_line[req_off*DATA_W +: DATA_W] : '0;
  assign c_busywait_o = reset_ni && ((state_q != StIdle) || miss_en);
  assign c_m_read_o   = m_rd_q;
  assign c_m_wr_o     = m_wr_q;

  always_comb begin
    c_m_address_o    = '0;
    c_m_write_data_o = '0;
    if (reset_ni) begin
      if (state_q == StWriteback) begin
        c_m_address_o    = {tag_q[miss_idx][victim_q], miss_idx};
        c_m_write_data_o = data_q[miss_idx][victim_q];
      end else if (state_q == StRefill) begin
        c_m_address_o = line_q;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_en && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_en && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_wb_set_assoc_cache.sv
// Directed bench for wb_set_assoc_cache: fills, write hits, dirty eviction, LRU order, reset.
// Build with CACHE_STATS_EN to also check the hit/miss counters.
module tb_wb_set_assoc_cache;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic [31:0]   address_i = '0;
  logic          c_read_i = 1'b0, c_wr_i = 1'b0;
  logic [31:0]   c_write_data_i = '0;
  logic [31:0]   c_data_o;
  logic          c_busywait_o, c_m_read_o, c_m_wr_o;
  logic [27:0]   c_m_address_o;
  logic [127:0]  c_m_write_data_o;
  logic [127:0]  c_m_read_data_i = '0;
  logic          c_m_busywait_i = 1'b0, m_read_done = 1'b0, m_write_done = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_set_assoc_cache dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .address_i        (address_i),
    .c_read_i         (c_read_i),
    .c_wr_i           (c_wr_i),
    .c_write_data_i   (c_write_data_i),
    .c_data_o         (c_data_o),
    .c_busywait_o     (c_busywait_o),
    .c_m_read_o       (c_m_read_o),
    .c_m_wr_o         (c_m_wr_o),
    .c_m_address_o    (c_m_address_o),
    .c_m_write_data_o (c_m_write_data_o),
    .c_m_read_data_i  (c_m_read_data_i),
    .c_m_busywait_i   (c_m_busywait_i),
    .m_read_done      (m_read_done),
    .m_write_done     (m_write_done)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory: word w of line la; line 0x004 gives 0x11111111, 0x22222222, ...
  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++)
      l[w*32 +: 32] = 32'h1111_1111 * (w + 1) + ((32'(la) - 32'd4) << 20);
    return l;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [127:0] l;
    int           off;
    l   = mem_line(28'(addr >> 4));
    off = int'(addr[3:2]);
    return l[off*32 +: 32];
  endfunction

  task automatic serve_refill(input logic [27:0] la);
    int n = 0;
    while (!c_m_read_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("refill_strobe", c_m_read_o, 1);
    if (!c_m_read_o) return;
    check_eq("refill_addr", c_m_address_o, la);
    check_eq("refill_no_wr", c_m_wr_o, 0);
    check_eq("refill_stall", c_busywait_o, 1);
    m_write_done = 1'b1;
    @(negedge clk_i);
    m_write_done = 1'b0;
    check_eq("refill_ignores_wdone", c_m_read_o, 1);
    c_m_read_data_i = mem_line(la);
    m_read_done     = 1'b1;
    c_m_busywait_i  = 1'b1;
    @(negedge clk_i);
    c_m_busywait_i = 1'b0;
    check_eq("refill_waits_mem_busy", c_m_read_o, 1);
    @(negedge clk_i);
    m_read_done     = 1'b0;
    c_m_read_data_i = '0;
    check_eq("refill_strobe_off", c_m_read_o, 0);
  endtask

  task automatic serve_writeback(input logic [27:0] la, input logic [127:0] line);
    int n = 0;
    while (!c_m_wr_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("wb_strobe", c_m_wr_o, 1);
    if (!c_m_wr_o) return;
    check_eq("wb_addr", c_m_address_o, la);
    check_eq("wb_data", c_m_write_data_o, line);
    check_eq("wb_no_rd", c_m_read_o, 0);
    m_read_done = 1'b1;
    @(negedge clk_i);
    m_read_done = 1'b0;
    check_eq("wb_ignores_rdone", c_m_wr_o, 1);
    m_write_done = 1'b1;
    @(negedge clk_i);
    m_write_done = 1'b0;
    check_eq("wb_strobe_off", c_m_wr_o, 0);
    check_eq("wb_to_refill", c_m_read_o, 1);
  endtask

  task automatic cpu_rd_hit(input logic [31:0] addr, input logic [31:0] exp);
    address_i = addr;
    c_read_i  = 1'b1;
    c_wr_i    = 1'b0;
    #1;
    check_eq($sformatf("rd_hit_busy %0h", addr), c_busywait_o, 0);
    check_eq($sformatf("rd_hit_data %0h", addr), c_data_o, exp);
    @(negedge clk_i);
    c_read_i = 1'b0;
  endtask

  task automatic cpu_wr_hit(input logic [31:0] addr, input logic [31:0] data, input logic rd,
                            input logic [31:0] exp_pre);
    address_i      = addr;
    c_write_data_i = data;
    c_wr_i         = 1'b1;
    c_read_i       = rd;
    #1;
    check_eq($sformatf("wr_hit_busy %0h", addr), c_busywait_o, 0);
    check_eq($sformatf("wr_hit_pre %0h", addr), c_data_o, exp_pre);
    check_eq("wr_hit_no_mem", {c_m_wr_o, c_m_read_o}, 2'b00);
    @(negedge clk_i);
    c_wr_i   = 1'b0;
    c_read_i = 1'b0;
  endtask

  task automatic cpu_miss(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                          input logic do_wb, input logic [27:0] wb_la, input logic [127:0] wb_line);
    address_i      = addr;
    c_write_data_i = data;
    c_wr_i         = wr;
    c_read_i       = !wr;
    #1;
    check_eq($sformatf("miss_stall %0h", addr), c_busywait_o, 1);
    check_eq("idle_strobes", {c_m_wr_o, c_m_read_o}, 2'b00);
    @(negedge clk_i);
    if (do_wb) serve_writeback(wb_la, wb_line);
    else check_eq("no_writeback", c_m_wr_o, 0);
    serve_refill(28'(addr >> 4));
    check_eq($sformatf("miss_done_busy %0h", addr), c_busywait_o, 0);
    check_eq($sformatf("miss_done_data %0h", addr), c_data_o, mem_word(addr));
    @(negedge clk_i);
    c_wr_i   = 1'b0;
    c_read_i = 1'b0;
  endtask

  initial begin
    // Reset with a pending read: every CPU/memory output must stay quiet.
    address_i = 32'h40;
    c_read_i  = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("rst_busy", c_busywait_o, 0);
    check_eq("rst_data", c_data_o, 0);
    check_eq("rst_strobes", {c_m_wr_o, c_m_read_o}, 2'b00);
    check_eq("rst_addr", c_m_address_o, 0);
    check_eq("rst_wdata", c_m_write_data_o, 0);
    c_read_i = 1'b0;
    reset_ni = 1'b1;
    @(negedge clk_i);

    // Cold miss, then write hits (including read+write together) on the resident line.
    cpu_miss(32'h40, 1'b0, '0, 1'b0, '0, '0);
    cpu_wr_hit(32'h44, 32'hDEAD_BEEF, 1'b0, 32'h2222_2222);
    cpu_wr_hit(32'h48, 32'hCAFE_F00D, 1'b1, 32'h3333_3333);
    cpu_rd_hit(32'h44, 32'hDEAD_BEEF);
    cpu_rd_hit(32'h40, 32'h1111_1111);
    cpu_rd_hit(32'h48, 32'hCAFE_F00D);

    // Fill remaining ways of set 4; the fourth new tag evicts the dirty line at A.
    cpu_miss(32'h140, 1'b0, '0, 1'b0, '0, '0);
    cpu_miss(32'h240, 1'b0, '0, 1'b0, '0, '0);
    cpu_miss(32'h340, 1'b0, '0, 1'b0, '0, '0);
    cpu_miss(32'h440, 1'b0, '0, 1'b1, 28'h004,
             {32'h4444_4444, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1111_1111});

    // Touch ways 0,1,2,3 then 0: way 1 (0x140) becomes LRU.
    cpu_rd_hit(32'h440, mem_word(32'h440));
    cpu_rd_hit(32'h140, mem_word(32'h140));
    cpu_rd_hit(32'h240, mem_word(32'h240));
    cpu_rd_hit(32'h340, mem_word(32'h340));
    cpu_rd_hit(32'h440, mem_word(32'h440));
    cpu_miss(32'h540, 1'b0, '0, 1'b0, '0, '0);
    cpu_rd_hit(32'h440, mem_word(32'h440));
    cpu_rd_hit(32'h240, mem_word(32'h240));
    cpu_rd_hit(32'h340, mem_word(32'h340));
    cpu_miss(32'h140, 1'b0, '0, 1'b0, '0, '0);

    // Write miss merges the CPU word after the refill.
    cpu_miss(32'h64C, 1'b1, 32'h0BAD_F00D, 1'b0, '0, '0);
    cpu_rd_hit(32'h64C, 32'h0BAD_F00D);
    cpu_rd_hit(32'h648, mem_word(32'h648));

    // Reset in the middle of a refill; a done pulse during reset is ignored.
    address_i = 32'h40;
    c_read_i  = 1'b1;
    @(negedge clk_i);
    check_eq("pre_rst_refill", c_m_read_o, 1);
    reset_ni = 1'b0;
    #1;
    check_eq("mid_rst_rd_strobe", c_m_read_o, 0);
    check_eq("mid_rst_busy", c_busywait_o, 0);
    check_eq("mid_rst_addr", c_m_address_o, 0);
    c_m_read_data_i = mem_line(28'h004);
    m_read_done     = 1'b1;
    @(negedge clk_i);
    check_eq("mid_rst_data", c_data_o, 0);
    m_read_done     = 1'b0;
    c_m_read_data_i = '0;
    c_read_i        = 1'b0;
    reset_ni        = 1'b1;
    cpu_miss(32'h40, 1'b0, '0, 1'b0, '0, '0);
    cpu_miss(32'h140, 1'b0, '0, 1'b0, '0, '0);
    cpu_rd_hit(32'h40, 32'h1111_1111);
`ifdef CACHE_STATS_EN
    check_eq("hit_cnt", hit_cnt_o, 3);
    check_eq("miss_cnt", miss_cnt_o, 2);
`endif

    // A write request dropped mid-miss still fills the line, without merging.
    address_i      = 32'h740;
    c_write_data_i = 32'hFFFF_FFFF;
    c_wr_i         = 1'b1;
    #1;
    check_eq("drop_miss_stall", c_busywait_o, 1);
    @(negedge clk_i);
    c_wr_i = 1'b0;
    serve_refill(28'h074);
    cpu_rd_hit(32'h740, mem_word(32'h740));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_set_assoc_cache.md
WB_SET_ASSOC_CACHE -- requirements
Module: wb_set_assoc_cache

Interface
REQ-001 Parameter DATA_W, 32, word width in bits.
REQ-002 Parameter ADDR_W, 32, byte-address width.
REQ-003 Parameter WAY_BITS, 2, log2 of way count (WAYS = 2**WAY_BITS, 1..8 ways).
REQ-004 Parameter INDEX_BITS, 4, log2 of set count.
REQ-005 Parameter BLOCK_BITS, 2, log2 of words per line (LINE_W = DATA_W*2**BLOCK_BITS); TAG_W = ADDR_W-INDEX_BITS-BLOCK_BITS-2.
REQ-006 clk_i  in  1  single clock; all state changes on rising edge.
REQ-007 reset_ni  in  1  asynchronous, active-low reset.
REQ-008 address_i  in  ADDR_W  byte address {tag, index, offset, 2'b00}.
REQ-009 c_read_i / c_wr_i  in  1 each  CPU read / write request, held until c_busywait_o is low.
REQ-010 c_write_data_i  in  DATA_W  CPU write word.
REQ-011 c_data_o  out  DATA_W  read word; c_busywait_o  out  1  CPU stall.
REQ-012 c_m_read_o / c_m_wr_o  out  1 each  memory line read / write strobe.
REQ-013 c_m_address_o  out  ADDR_W-BLOCK_BITS-2  line address {tag,index}; c_m_write_data_o  out  LINE_W  victim line.
REQ-014 c_m_read_data_i  in  LINE_W; c_m_busywait_i, m_read_done, m_write_done  in  1 each.

Function
REQ-015 Lookup is combinational: hit = some way in set[index] is valid with tag match; c_data_o = word[offset] of the hit way, 0 on miss.
REQ-016 Read hit: c_busywait_o = 0 in the same cycle, zero-cycle latency.
REQ-017 Write hit: only word[offset] of the hit way is replaced at the clock edge, other words unchanged; dirty set to 1; c_busywait_o = 0.
REQ-018 Simultaneous c_read_i and c_wr_i are treated as a write; c_data_o shows pre-write data.
REQ-019 FSM states: IDLE, WRITEBACK, REFILL.
REQ-020 IDLE with a request and a miss: c_busywait_o = 1 combinationally; next state is WRITEBACK if the victim is valid and dirty, else REFILL.
REQ-021 WRITEBACK: c_m_wr_o = 1, address = {victim tag, index}, data = victim line; on m_write_done && !c_m_busywait_i go to REFILL and clear the victim's dirty bit.
REQ-022 REFILL: c_m_read_o = 1, address = address_i line address; on m_read_done && !c_m_busywait_i write the line into the victim way, set valid, load tag, clear dirty, and go to IDLE.
REQ-023 After a refill the request is replayed in IDLE as a hit, so a miss ends with busywait low one cycle after the refill completes.
REQ-024 Done pulses outside the matching state are ignored.
REQ-025 c_busywait_o = 1 in WRITEBACK and REFILL; strobes are 0 in IDLE.
REQ-026 Victim selection: the lowest-index invalid way; otherwise the way with LRU age WAYS-1.
REQ-027 True LRU: ages per set form a permutation of 0..WAYS-1; on any hit, the accessed way gets age 0 and ways with age below its old age increment.
REQ-028 If the request drops mid-miss, the in-flight memory transaction completes and the line is filled, with no CPU write merge.

Reset
REQ-029 reset_ni low, at any time including mid-transaction: FSM to IDLE; all valid and dirty bits to 0; LRU age of way i set to i; c_m_read_o = c_m_wr_o = 0.
REQ-030 During reset: c_busywait_o = 0, c_data_o = 0, c_m_address_o = 0, c_m_write_data_o = 0; any memory done pulse is ignored.

Configuration
REQ-031 With macro CACHE_STATS_EN defined, add outputs hit_cnt_o and miss_cnt_o (32 bits each, saturating).
REQ-032 The counters increment once per completed hit and once per miss entry from IDLE, and reset to 0.
REQ-033 Without CACHE_STATS_EN, those ports and their logic are absent; all other behaviour is identical.

Verification (defaults; A = 0x0000_0040, index 4, offset 0)
REQ-034 After reset, read A -> busywait=1, REFILL, c_m_address_o=0x004; return line word0=0x11111111 -> next cycle c_data_o=0x11111111, busywait=0.
REQ-035 Write 0xDEADBEEF to A+4 on the resident line -> no memory traffic; read A+4 = 0xDEADBEEF, A = 0x11111111; dirty=1.
REQ-036 Fill 4 further tags into index 4 (0x140, 0x240, 0x340, 0x440) -> the LRU way holding A (dirty) is written back first (c_m_wr_o=1, address 0x004, data holds 0xDEADBEEF), then refilled.
REQ-037 Access ways in order 0,1,2,3, then touch way 0 -> the next miss evicts way 1.
REQ-038 Assert reset_ni low during REFILL -> c_m_read_o=0 immediately, FSM in IDLE, next read of A misses.
REQ-039 With CACHE_STATS_EN, run 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2.
